// File: rtl/seven_segment_scan_controller.sv
// Multiplexed seven-segment scan controller with a guarded digit
// sequence and a one-entry update buffer applied only at frame end.
module seven_segment_scan_controller #(
   parameter int NUM_DIGITS = 4,
   parameter int DWELL      = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   input  logic [4*NUM_DIGITS-1:0] upd_data,
   input  logic                    lz_blank,
   output logic [3:0]              bcd_out,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    blank,
   output logic                    frame_done
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(DWELL + 2);

   typedef enum logic {
      GUARD,
      ON
   } state_t;

   state_t                state, state_nxt;
   logic [IW-1:0]         idx, idx_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic [W-1:0]          disp, disp_nxt;
   logic [W-1:0]          pend, pend_nxt;
   logic                  pend_full, pend_full_nxt;
   logic [3:0]            bcd_nxt;
   logic [NUM_DIGITS-1:0] an_nxt;
   logic                  blank_nxt;
   logic                  fd_nxt;
   logic                  z;
   logic                  lzk;

   assign upd_ready = !pend_full;

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      cnt_nxt       = cnt + 1'b1;
      disp_nxt      = disp;
      pend_nxt      = pend;
      pend_full_nxt = pend_full;
      bcd_nxt       = 4'd0;
      an_nxt        = '1;
      blank_nxt     = 1'b1;
      fd_nxt        = 1'b0;
      z             = 1'b1;
      lzk           = 1'b0;

      unique case (state)
         GUARD: begin
            if (cnt == CW'(1)) begin
               state_nxt = ON;
               cnt_nxt   = '0;
            end
         end
         ON: begin
            if (cnt == CW'(DWELL - 1)) begin
               state_nxt = GUARD;
               cnt_nxt   = '0;
               if (idx == IW'(NUM_DIGITS - 1))
                  idx_nxt = '0;
               else
                  idx_nxt = idx + 1'b1;
            end
         end
      endcase

      // buffer drains only at the frame boundary so a frame never tears
      if (frame_done && pend_full) begin
         disp_nxt      = pend;
         pend_full_nxt = 1'b0;
      end
      if (upd_valid && upd_ready) begin
         pend_nxt      = upd_data;
         pend_full_nxt = 1'b1;
      end

      // z: all digits from the top down to k are zero
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         z = z && (disp_nxt[4*k +: 4] == 4'd0);
         if (IW'(k) == idx_nxt) begin
            bcd_nxt = disp_nxt[4*k +: 4];
            lzk     = z && (k != 0);
         end
      end

      if (state_nxt == ON) begin
         an_nxt[idx_nxt] = 1'b0;
         blank_nxt = (bcd_nxt > 4'd9) || (lz_blank && lzk);
         fd_nxt = (idx_nxt == IW'(NUM_DIGITS - 1)) &&
                  (cnt_nxt == CW'(DWELL - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= GUARD;
         idx        <= '0;
         cnt        <= '0;
         disp       <= '0;
         pend       <= '0;
         pend_full  <= 1'b0;
         an_n       <= '1;
         bcd_out    <= 4'd0;
         blank      <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         disp       <= disp_nxt;
         pend       <= pend_nxt;
         pend_full  <= pend_full_nxt;
         an_n       <= an_nxt;
         bcd_out    <= bcd_nxt;
         blank      <= blank_nxt;
         frame_done <= fd_nxt;
      end
   end

endmodule

// File: doc/seven_segment_scan_controller.md
SEVEN_SEGMENT_SCAN_CONTROLLER -- requirements
Module: seven_segment_scan_controller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digit positions (2..8).
REQ-002 SHALL have parameter DWELL, default 1000, meaning the clock cycles each digit is lit per visit (>=1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port upd_valid, input, 1 bit: a new display value is offered.
REQ-006 SHALL have port upd_ready, output, 1 bit: the controller can accept a value this cycle.
REQ-007 SHALL have port upd_data, input, 4*NUM_DIGITS bits: BCD digits, with digit 0 (least significant) in bits [3:0].
REQ-008 SHALL have port lz_blank, input, 1 bit: enable leading-zero blanking.
REQ-009 SHALL have port bcd_out, output, 4 bits: BCD code driven to the shared seven-segment decoder.
REQ-010 SHALL have port an_n, output, NUM_DIGITS bits: active-low digit enables, with bit k selecting digit k.
REQ-011 SHALL have port blank, output, 1 bit: when high, the downstream logic suppresses all segments.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each full scan.

Function
REQ-013 SHALL time-share one decoder: registers disp (the shown value) and pend (a one-entry buffer) plus flag pend_full.
REQ-014 SHALL run a two-state FSM per digit: GUARD for 2 cycles, then ON for DWELL cycles, then GUARD of the next digit.
REQ-015 SHALL, in GUARD, drive an_n all ones and blank=1; bcd_out holds the code of the digit about to be lit.
REQ-016 SHALL, in ON, drive an_n with only bit idx low and bcd_out=disp[4*idx+3:4*idx].
REQ-017 SHALL advance idx 0,1,...,NUM_DIGITS-1 and wrap to 0, giving a frame length of NUM_DIGITS*(DWELL+2) cycles.
REQ-018 SHALL pulse frame_done high for exactly the last ON cycle of digit NUM_DIGITS-1.
REQ-019 SHALL drive upd_ready = !pend_full (combinational from the register).
REQ-020 SHALL, on upd_valid&&upd_ready, capture upd_data into pend and set pend_full on the same edge.
REQ-021 SHALL copy pend to disp and clear pend_full on the frame_done edge when pend_full=1, so the display never tears mid-frame.
REQ-022 SHALL, when a value is accepted on the frame_done edge, only buffer that value; it is applied at the following frame boundary.
REQ-023 SHALL hold pend and upd_ready=0 while pend_full=1; upd_valid is ignored.
REQ-024 SHALL, in ON, assert blank=1 when the current digit code is >9 (invalid BCD).
REQ-025 SHALL, when lz_blank=1, blank digit k in ON if disp digits NUM_DIGITS-1..k are all zero and k!=0; digit 0 is never leading-zero blanked.
REQ-026 SHALL register all outputs except upd_ready; output changes occur only on clk edges.
REQ-027 SHALL use a dwell counter of width ceil(log2(DWELL+2)) that resets to 0 at each state change; no overflow is permitted.

Reset
REQ-028 SHALL, while rst=1 at an edge: state=GUARD, idx=0, counter=0, disp=0, pend=0, pend_full=0, an_n all ones, bcd_out=0, blank=1, frame_done=0.
REQ-029 SHALL give rst priority over every other event, including a handshake or frame_done in the same cycle; a pending value is discarded.
REQ-030 SHALL have upd_ready=1 in the first cycle after reset release; digit 0 enters ON on cycle 2 after release.

Verification (NUM_DIGITS=4, DWELL=4)
REQ-031 SHALL be verified as follows: reset, then idle -> an_n=1110 on cycles 2-5, 1111 on cycles 6-7, 1101 on cycles 8-11, and so on; frame_done on cycle 23; repeats every 24 cycles.
REQ-032 SHALL be verified as follows: upd_data=16'h1234 accepted mid-frame -> digits still show 0 until frame_done; the next frame shows bcd_out 4,3,2,1 for digits 0..3.
REQ-033 SHALL be verified as follows: second upd_valid while pend_full -> upd_ready=0, value dropped, first value is displayed, and upd_ready returns to 1 the cycle after frame_done.
REQ-034 SHALL be verified as follows: lz_blank=1, disp=16'h0050 -> blank=1 in ON for digits 3 and 2, blank=0 for digits 1 and 0; with disp=0, only digit 0 is unblanked.
REQ-035 SHALL be verified as follows: disp digit 2 = 4'hB -> blank=1 during digit 2 ON only.
REQ-036 SHALL be verified as follows: rst asserted during digit 2 ON with pend_full=1 -> next cycle an_n=1111, blank=1, disp=0, upd_ready=1.
